// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: N-source prioritised interrupt controller for the Otter MCU.
// Synchronises raw peripheral IRQ lines, tracks them as edge- or level-mode
// pending bits, and drives one registered interrupt request to the MCU. The MCU
// acknowledges with int_ack, which claims the lowest-index enabled pending source.
// Software completes the claim by writing the CLAIM register.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   irq_src      raw asynchronous interrupt lines, active-high
//   iobus_addr   MCU iobus byte address
//   iobus_wdata  MCU iobus write data
//   iobus_wr     MCU iobus write strobe (one cycle per store)
//   rd_data      combinational register read data for iobus_addr
//   int_ack      MCU int_taken acknowledge pulse
//   intrpt       registered interrupt request to the MCU
//   claim_id     registered in-service source index + 1 (0 = none)
//
// Register map (word offsets from BASE_ADDR, byte lanes ignored):
//   0x00 PEND   R, write-1-to-clear on edge-mode bits
//   0x04 ENABLE R/W
//   0x08 MODE   R/W (1 = edge, 0 = level)
//   0x0C CLAIM  R claim_id, any write completes the claim
//   0x10 STATUS R [1:0] state, [8] intrpt
module otter_intr_ctrl #(
  parameter int unsigned N_SRC       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [31:0]      iobus_addr,
  input  logic [31:0]      iobus_wdata,
  input  logic             iobus_wr,
  output logic [31:0]      rd_data,
  input  logic             int_ack,
  output logic             intrpt,
  output logic [5:0]       claim_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_CLAIMED = 2'd2
  } state_t;

  state_t state_q;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] det_q;
  logic [N_SRC-1:0] sync_level;
  logic [N_SRC-1:0] edge_rise;

  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] mode_q;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] claim_mask;
  logic [N_SRC-1:0] clr_mask;
  logic [N_SRC-1:0] wdata_src;
  logic [5:0]       win_id;
  logic             take;

  logic             reg_hit;
  logic [2:0]       reg_sel;
  logic             wr_pend;
  logic             wr_enable;
  logic             wr_mode;
  logic             wr_claim;

  logic [31:0]      pend_ext;
  logic [31:0]      enable_ext;
  logic [31:0]      mode_ext;
  logic             unused_bits;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      det_q <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      det_q <= sync_level;
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1];
  assign edge_rise  = sync_level & ~det_q;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign reg_hit   = (iobus_addr[31:5] == BASE_ADDR[31:5]);
  assign reg_sel   = iobus_addr[4:2];
  assign wr_pend   = iobus_wr && reg_hit && (reg_sel == 3'd0);
  assign wr_enable = iobus_wr && reg_hit && (reg_sel == 3'd1);
  assign wr_mode   = iobus_wr && reg_hit && (reg_sel == 3'd2);
  assign wr_claim  = iobus_wr && reg_hit && (reg_sel == 3'd3);
  assign wdata_src = iobus_wdata[N_SRC-1:0];

  // Byte-lane bits and write-data bits above N_SRC carry no meaning here.
  assign unused_bits = ^{iobus_addr[1:0], iobus_wdata};

  // ---------------------------------------------------------------------------
  // Priority select: lowest index among enabled pending sources
  // ---------------------------------------------------------------------------
  assign active = pend_q & enable_q;

  // Scanning downwards lets the lowest set index overwrite any higher one.
  always_comb begin
    win_id     = '0;
    claim_mask = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (active[i-1]) begin
        win_id          = 6'(i);
        claim_mask      = '0;
        claim_mask[i-1] = 1'b1;
      end
    end
  end

  assign take     = (state_q == ST_REQ) && int_ack && (|active);
  assign clr_mask = (wr_pend ? wdata_src : '0) | (take ? claim_mask : '0);

  // ---------------------------------------------------------------------------
  // Pending / enable / mode registers
  // ---------------------------------------------------------------------------
  // Edge bits: clear first, then OR in a new edge so a same-cycle edge wins.
  // Level bits simply track the synchronised line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
    end else begin
      pend_q <= (mode_q & ((pend_q & ~clr_mask) | edge_rise)) |
                (~mode_q & sync_level);
      if (wr_enable) begin
        enable_q <= wdata_src;
      end
      if (wr_mode) begin
        mode_q <= wdata_src;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request / claim / complete FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      intrpt   <= 1'b0;
      claim_id <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|active) begin
            state_q <= ST_REQ;
            intrpt  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!(|active)) begin
            state_q <= ST_IDLE;
            intrpt  <= 1'b0;
          end else if (int_ack) begin
            state_q  <= ST_CLAIMED;
            claim_id <= win_id;
            intrpt   <= 1'b0;
          end
        end
        ST_CLAIMED: begin
          if (wr_claim) begin
            state_q  <= ST_IDLE;
            claim_id <= '0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          intrpt   <= 1'b0;
          claim_id <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_ext               = '0;
    enable_ext             = '0;
    mode_ext               = '0;
    pend_ext[N_SRC-1:0]    = pend_q;
    enable_ext[N_SRC-1:0]  = enable_q;
    mode_ext[N_SRC-1:0]    = mode_q;
  end

  always_comb begin
    rd_data = '0;
    if (reg_hit) begin
      case (reg_sel)
        3'd0:    rd_data = pend_ext;
        3'd1:    rd_data = enable_ext;
        3'd2:    rd_data = mode_ext;
        3'd3:    rd_data = {26'd0, claim_id};
        3'd4:    rd_data = {23'd0, intrpt, 6'd0, state_q};
        default: rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Testbench for otter_intr_ctrl: directed vector table, hand-written reset
// sequences, then randomized traffic checked against a behavioural model.
module tb_otter_intr_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned SS = 2;
  localparam logic [31:0] BASE = 32'h1100_0100;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_wdata;
  logic        iobus_wr;
  logic [31:0] rd_data;
  logic        int_ack;
  logic        intrpt;
  logic [5:0]  claim_id;

  int checks;
  int failures;

  otter_intr_ctrl #(
    .N_SRC(N),
    .BASE_ADDR(BASE),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .irq_src(irq_src),
    .iobus_addr(iobus_addr),
    .iobus_wdata(iobus_wdata),
    .iobus_wr(iobus_wr),
    .rd_data(rd_data),
    .int_ack(int_ack),
    .intrpt(intrpt),
    .claim_id(claim_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  task automatic rd_chk(input string nm, input int off, input logic [31:0] exp);
    iobus_addr = BASE + 32'(off * 4);
    #1;
    chk(nm, rd_data, exp);
  endtask

  task automatic wr_reg(input int off, input logic [31:0] data);
    iobus_addr  = BASE + 32'(off * 4);
    iobus_wdata = data;
    iobus_wr    = 1'b1;
    @(posedge clk);
    #1;
    iobus_wr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit        wr;
    bit [2:0]  off;
    bit [31:0] data;
    bit [7:0]  irq;
    bit        ack;
    bit        e_int;
    bit [5:0]  e_claim;
    bit [7:0]  e_pend;
    bit [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit wr, input bit [2:0] off, input bit [31:0] data,
                     input bit [7:0] irq, input bit ack, input bit e_int,
                     input bit [5:0] e_claim, input bit [7:0] e_pend,
                     input bit [1:0] e_state);
    vec_t v;
    v.wr = wr; v.off = off; v.data = data; v.irq = irq; v.ack = ack;
    v.e_int = e_int; v.e_claim = e_claim; v.e_pend = e_pend; v.e_state = e_state;
    vecs.push_back(v);
  endtask

  task automatic fill_table();
    // edge path on source 2
    add(1, 1, 32'h05, 8'h00, 0, 0, 0, 8'h00, 0);
    add(1, 2, 32'h05, 8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h04, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h04, 0);
    add(0, 0, 0,      8'h00, 0, 1, 0, 8'h04, 1);
    add(0, 0, 0,      8'h00, 1, 0, 3, 8'h00, 2);
    add(0, 0, 0,      8'h00, 0, 0, 3, 8'h00, 2);
    add(1, 3, 0,      8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h00, 0);
    // priority: sources 5 and 1 together
    add(1, 1, 32'hFF, 8'h00, 0, 0, 0, 8'h00, 0);
    add(1, 2, 32'hFF, 8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h22, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h22, 0);
    add(0, 0, 0,      8'h00, 0, 1, 0, 8'h22, 1);
    add(0, 0, 0,      8'h00, 1, 0, 2, 8'h20, 2);
    add(1, 3, 0,      8'h00, 0, 0, 0, 8'h20, 0);
    add(0, 0, 0,      8'h00, 0, 1, 0, 8'h20, 1);
    add(0, 0, 0,      8'h00, 1, 0, 6, 8'h00, 2);
    add(1, 3, 0,      8'h00, 0, 0, 0, 8'h00, 0);
    // collision: edge set and W1C together, then ack with CLAIM write
    add(0, 0, 0,      8'h08, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h00, 0);
    add(1, 0, 32'h08, 8'h00, 0, 0, 0, 8'h08, 0);
    add(0, 0, 0,      8'h00, 0, 1, 0, 8'h08, 1);
    add(1, 3, 0,      8'h00, 1, 0, 4, 8'h00, 2);
    add(0, 0, 0,      8'h00, 0, 0, 4, 8'h00, 2);
    add(1, 3, 0,      8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h00, 1, 0, 0, 8'h00, 0);
    // abort: CLAIM write in REQ ignored, ENABLE cleared in REQ
    add(0, 0, 0,      8'h01, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h01, 0);
    add(0, 0, 0,      8'h00, 0, 1, 0, 8'h01, 1);
    add(1, 3, 0,      8'h00, 0, 1, 0, 8'h01, 1);
    add(1, 1, 32'h00, 8'h00, 0, 1, 0, 8'h01, 1);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h01, 0);
    add(1, 0, 32'h01, 8'h00, 0, 0, 0, 8'h00, 0);
    // top source index, disable while claimed, ack while claimed
    add(1, 1, 32'hFF, 8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h80, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h80, 0);
    add(0, 0, 0,      8'h00, 0, 1, 0, 8'h80, 1);
    add(0, 0, 0,      8'h00, 1, 0, 8, 8'h00, 2);
    add(1, 1, 32'h00, 8'h00, 0, 0, 8, 8'h00, 2);
    add(0, 0, 0,      8'h00, 1, 0, 8, 8'h00, 2);
    add(1, 3, 0,      8'h00, 0, 0, 0, 8'h00, 0);
    // level mode on source 0
    add(1, 2, 32'h00, 8'h00, 0, 0, 0, 8'h00, 0);
    add(1, 1, 32'h01, 8'h00, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h01, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h01, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0,      8'h01, 0, 0, 0, 8'h01, 0);
    add(0, 0, 0,      8'h01, 0, 1, 0, 8'h01, 1);
    add(0, 0, 0,      8'h01, 1, 0, 1, 8'h01, 2);
    add(1, 3, 0,      8'h01, 0, 0, 0, 8'h01, 0);
    add(0, 0, 0,      8'h01, 0, 1, 0, 8'h01, 1);
    add(0, 0, 0,      8'h00, 0, 1, 0, 8'h01, 1);
    add(1, 0, 32'h01, 8'h00, 0, 1, 0, 8'h01, 1);
    add(0, 0, 0,      8'h00, 0, 1, 0, 8'h00, 1);
    add(0, 0, 0,      8'h00, 0, 0, 0, 8'h00, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  // hist[k] is the irq_src value captured k+1 edges ago; a source becomes
  // visible to the pending logic once it is SYNC_STAGES-1 entries deep.
  bit [7:0] m_hist [SS+1];
  bit [7:0] m_pend, m_en, m_mode;
  int       m_state;
  bit       m_int;
  int       m_claim;

  task automatic model_reset();
    for (int k = 0; k <= SS; k++) m_hist[k] = '0;
    m_pend = '0; m_en = '0; m_mode = '0;
    m_state = 0; m_int = 0; m_claim = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return '0;
    case (a[4:2])
      3'd0: return {24'd0, m_pend};
      3'd1: return {24'd0, m_en};
      3'd2: return {24'd0, m_mode};
      3'd3: return 32'(m_claim);
      3'd4: return 32'(m_state) + (m_int ? 32'd256 : 32'd0);
      default: return '0;
    endcase
  endfunction

  task automatic model_step(input bit [7:0] irq, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input bit ack);
    bit [7:0] lvl, rise, act, low, clr, npend;
    bit       hit;
    int       sel;
    lvl  = m_hist[SS-1];
    rise = lvl & ~m_hist[SS];
    act  = m_pend & m_en;
    low  = act & (~act + 8'd1);
    hit  = wr && (a[31:5] == BASE[31:5]);
    sel  = int'(a[4:2]);
    clr  = '0;
    if (hit && sel == 0) clr = clr | d[7:0];
    if (m_state == 1 && act != 0 && ack) clr = clr | low;
    npend = (m_mode & ((m_pend & ~clr) | rise)) | (~m_mode & lvl);
    case (m_state)
      0: if (act != 0) begin m_state = 1; m_int = 1; end
      1: begin
        if (act == 0) begin
          m_state = 0; m_int = 0;
        end else if (ack) begin
          m_state = 2; m_int = 0; m_claim = $clog2(low) + 1;
        end
      end
      default: if (hit && sel == 3) begin m_state = 0; m_claim = 0; end
    endcase
    m_pend = npend;
    if (hit && sel == 1) m_en = d[7:0];
    if (hit && sel == 2) m_mode = d[7:0];
    for (int k = SS; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = irq;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] a, d;
    bit          w, k;
    bit [7:0]    q;

    checks = 0;
    failures = 0;
    rst = 1'b0;
    irq_src = '0;
    iobus_addr = BASE;
    iobus_wdata = '0;
    iobus_wr = 1'b0;
    int_ack = 1'b0;

    // reset held while sources toggle
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      irq_src = (c % 2 == 0) ? 8'hFF : 8'h00;
      chk("rst_intrpt", {31'd0, intrpt}, 0);
      chk("rst_claim", {26'd0, claim_id}, 0);
      for (int r = 0; r < 5; r++) rd_chk("rst_reg", r, 0);
    end
    irq_src = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_intrpt", {31'd0, intrpt}, 0);
      for (int r = 0; r < 5; r++) rd_chk("post_rst_reg", r, 0);
    end

    // directed vectors
    fill_table();
    foreach (vecs[i]) begin
      iobus_addr  = BASE + {27'd0, vecs[i].off, 2'b00};
      iobus_wdata = vecs[i].data;
      iobus_wr    = vecs[i].wr;
      irq_src     = vecs[i].irq;
      int_ack     = vecs[i].ack;
      @(posedge clk);
      #1;
      iobus_wr = 1'b0;
      int_ack  = 1'b0;
      chk($sformatf("v%0d_intrpt", i), {31'd0, intrpt}, {31'd0, vecs[i].e_int});
      chk($sformatf("v%0d_claim", i), {26'd0, claim_id}, {26'd0, vecs[i].e_claim});
      rd_chk($sformatf("v%0d_pend", i), 0, {24'd0, vecs[i].e_pend});
      rd_chk($sformatf("v%0d_status", i), 4,
             {23'd0, vecs[i].e_int, 6'd0, vecs[i].e_state});
    end

    // reset while CLAIMED, with a fresh edge still in the synchroniser
    irq_src = '0;
    wr_reg(2, 32'hFF);
    wr_reg(1, 32'hFF);
    irq_src = 8'h10;
    @(posedge clk);
    #1;
    irq_src = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_req_intrpt", {31'd0, intrpt}, 1);
    int_ack = 1'b1;
    @(posedge clk);
    #1;
    int_ack = 1'b0;
    chk("mid_claim", {26'd0, claim_id}, 5);
    irq_src = 8'h10;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_claim", {26'd0, claim_id}, 0);
    chk("async_rst_intrpt", {31'd0, intrpt}, 0);
    rd_chk("async_rst_status", 4, 0);
    rd_chk("async_rst_enable", 1, 0);
    irq_src = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      chk("leak_intrpt", {31'd0, intrpt}, 0);
      rd_chk("leak_pend", 0, 0);
    end

    // randomized traffic against the model
    model_reset();
    q = '0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(3) == 0) q = 8'($urandom);
      w = ($urandom_range(4) == 0);
      k = ($urandom_range(3) == 0);
      a = BASE + 32'($urandom_range(5) * 4) + 32'($urandom_range(3));
      if ($urandom_range(15) == 0) a = a ^ 32'h0000_1000;
      d = $urandom;
      if ($urandom_range(1) == 0) d = {24'd0, d[7:0] | d[15:8]};
      irq_src     = q;
      iobus_addr  = a;
      iobus_wdata = d;
      iobus_wr    = w;
      int_ack     = k;
      model_step(q, w, a, d, k);
      @(posedge clk);
      #1;
      iobus_wr = 1'b0;
      int_ack  = 1'b0;
      chk("rnd_intrpt", {31'd0, intrpt}, {31'd0, m_int});
      chk("rnd_claim", {26'd0, claim_id}, 32'(m_claim));
      chk("rnd_rd_data", rd_data, model_read(a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otter_intr_ctrl.md
Name: otter_intr_ctrl

Overview:
- Parametrised N-source interrupt controller for the Otter MCU; replaces the single raw `intrpt` line with prioritised, maskable, claimable sources.
- Sits between peripheral IRQ lines and the MCU `intrpt` input. Software programs it through the MCU iobus (memory-mapped).
- Consumes the MCU `int_taken` pulse as an acknowledge and runs a claim/complete in-service handshake.
- Supports per-source edge or level mode.

Parameters:
- N_SRC, 8, number of interrupt sources, legal range 1..32
- BASE_ADDR, 32'h1100_0100, byte address of register 0; must be 32-byte aligned
- SYNC_STAGES, 2, flip-flop synchroniser depth per source, legal range 2..3

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- irq_src  in  N_SRC  raw asynchronous peripheral interrupt lines, active-high
- iobus_addr  in  32  MCU iobus address
- iobus_wdata  in  32  MCU iobus write data
- iobus_wr  in  1  MCU iobus write strobe, one cycle per store
- rd_data  out  32  register read data, combinational from iobus_addr; routed to MCU iobus_in
- int_ack  in  1  MCU int_taken, one-cycle pulse
- intrpt  out  1  registered interrupt request to MCU
- claim_id  out  6  registered in-service source index + 1; 0 = none

Behaviour:
- Reset (rst low, async): all synchroniser, pending, enable, mode, claim and state flops clear. intrpt=0, claim_id=0, state=IDLE. rd_data follows the cleared registers.
- Sources: each irq_src[i] passes through SYNC_STAGES flops, then one edge-detect flop.
- Edge mode (MODE[i]=1): a rising edge sets PEND[i]. PEND[i] stays set until a W1C write clears it or the source is claimed.
- Level mode (MODE[i]=0): PEND[i] equals the synchronised level. W1C has no effect, and claiming does not clear it.
- Latency: an irq_src rise at edge k makes PEND visible after edge k+SYNC_STAGES+1. intrpt rises on the next edge.
- Register map (word offsets; byte lanes ignored; bits ≥ N_SRC read 0):
  - +0x00 PEND: R; write-1-to-clear on edge-mode bits
  - +0x04 ENABLE: R/W
  - +0x08 MODE: R/W
  - +0x0C CLAIM: R returns claim_id; any write = complete
  - +0x10 STATUS: R; [1:0]=state, [8]=intrpt
  - Other addresses read 0 and ignore writes.
- Priority: the lowest index among (PEND & ENABLE) wins. Selection is combinational and resolved on the int_ack edge.
- FSM:
  - IDLE: go to REQ when |(PEND&ENABLE).
  - REQ: intrpt=1.
    - int_ack → CLAIMED: latch winner into claim_id; clear PEND[winner] if edge mode; intrpt=0.
    - If (PEND&ENABLE) becomes 0 before ack → IDLE, intrpt=0.
  - CLAIMED: intrpt=0. Write to CLAIM → IDLE, claim_id=0.
  - No nesting; new pendings accumulate and re-request after complete.
- Boundary conditions:
  - Edge set and W1C on the same bit in the same cycle: set wins.
  - Simultaneous int_ack and a CLAIM write in REQ: ack processed, write ignored.
  - int_ack in IDLE or CLAIMED: ignored.
  - CLAIM write in IDLE or REQ: ignored.
  - Disabling the claimed source while in CLAIMED: stays CLAIMED until complete.
  - ENABLE cleared while in REQ: drops to IDLE next cycle.
  - Reset mid-operation: immediate clear; no request leaks out after release.
  - Source index N_SRC-1: claim_id = N_SRC.
- Widths: claim_id is zero-extended to 32 on read.

Test Plan:
- Reset: hold rst=0, toggle irq_src=8'hFF → intrpt=0, every register reads 0. After release, reads still 0 until ENABLE is written.
- Edge path: write ENABLE=0x05, MODE=0x05; pulse irq_src[2] high for 1 cycle → PEND=0x04 after 3 edges, intrpt=1 on the 4th. int_ack → claim_id=3, PEND=0, intrpt=0. Write CLAIM → state IDLE.
- Priority: ENABLE=0xFF, MODE=0xFF; raise irq_src[5] and irq_src[1] together → ack gives claim_id=2. After complete, intrpt re-asserts and the next ack gives claim_id=6.
- Level mode: MODE=0, ENABLE=0x01, hold irq_src[0]=1 → ack gives claim_id=1. After complete, intrpt=1 again. Drop the source and write W1C=0x01 → PEND=0, intrpt=0.
- Collision: in the same cycle, an edge on bit 3 and a write of PEND=0x08 → PEND[3]=1. In REQ, int_ack plus a CLAIM write → claim_id latched, state CLAIMED.
- Abort: in REQ, write ENABLE=0 → intrpt=0 next cycle, state IDLE. Assert rst mid-CLAIMED → claim_id=0 immediately.
